uart_tx_only3: RTL

- UART transmitter; the transmit-side counterpart to the team's 16x-oversampled UART receiver.
- Accepts bytes from the host through a one-deep holding register and serialises them on txd: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from the shared 16x baud enable (bclk), so both directions share one baud generator.

---
 rtl/uart_tx_only3_if.sv | 13 +
 rtl/uart_tx_only3.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_only3_if.sv
// Host-side handshake bundle for the UART transmitter: byte write strobe and
// holding-register / frame status flags.
interface uart_tx_only3_if;
  logic [7:0] din;
  logic       load;
  logic       empty;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (output din, load, input empty, busy, done, overrun);
  modport slave  (input din, load, output empty, busy, done, overrun);
endinterface

// File: rtl/uart_tx_only3.sv
// UART transmitter paced by a shared 16x baud enable: one-deep holding register,
// start / 8 data LSB-first / optional parity / 1-2 stop bits on a registered txd.
module uart_tx_only3 #(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bclk,
  uart_tx_only3_if.slave   host,
  output logic             txd,
  output logic [3:0]       CS
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA   = 4'd2,
    PARITY = 4'd3,
    STOP   = 4'd4
  } state_t;

  localparam logic       ODD_L      = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);

  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [7:0] hold_r, shift_r, shift_nxt_s;
  logic [3:0] bitcnt_r, bitcnt_nxt_s, bitcnt_inc_s;
  logic [2:0] bitidx_r, bitidx_nxt_s;
  logic       empty_r, par_r, txd_r, busy_r, done_r, overrun_r;
  logic       tick_s, load_frame_s, done_nxt_s, txd_nxt_s;

  assign tick_s       = bclk && (bitcnt_r == 4'd15);
  assign bitcnt_inc_s = bclk ? (bitcnt_r + 4'd1) : bitcnt_r;

  // Next-state, bit sequencing and baud counter for the frame FSM.
  always_comb begin
    state_nxt_s  = state_r;
    shift_nxt_s  = shift_r;
    bitcnt_nxt_s = bitcnt_r;
    bitidx_nxt_s = bitidx_r;
    load_frame_s = 1'b0;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_r) begin
          state_nxt_s  = START;
          shift_nxt_s  = hold_r;
          bitcnt_nxt_s = 4'd0;
          bitidx_nxt_s = 3'd0;
          load_frame_s = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      START: begin
        bitcnt_nxt_s = bitcnt_inc_s;
        if (tick_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        bitcnt_nxt_s = bitcnt_inc_s;
        if (tick_s) begin
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (bitidx_r == 3'd7) begin
            bitidx_nxt_s = 3'd0;
            state_nxt_s  = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitidx_nxt_s = bitidx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        bitcnt_nxt_s = bitcnt_inc_s;
        if (tick_s) begin
          state_nxt_s  = STOP;
          bitidx_nxt_s = 3'd0;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        bitcnt_nxt_s = bitcnt_inc_s;
        // bitidx is reused to count stop-bit periods
        if (tick_s) begin
          if (bitidx_r == LAST_STOP) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            bitidx_nxt_s = bitidx_r + 3'd1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so txd is registered alongside it.
  always_comb begin
    txd_nxt_s = 1'b1;
    case (state_nxt_s)
      START:   txd_nxt_s = 1'b0;
      DATA:    txd_nxt_s = shift_nxt_s[0];
      PARITY:  txd_nxt_s = par_r;
      default: txd_nxt_s = 1'b1;
    endcase
  end

  // Frame state, shift register, counters and registered line outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      shift_r  <= 8'd0;
      bitcnt_r <= 4'd0;
      bitidx_r <= 3'd0;
      par_r    <= 1'b0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shift_r  <= shift_nxt_s;
      bitcnt_r <= bitcnt_nxt_s;
      bitidx_r <= bitidx_nxt_s;
      if (load_frame_s) begin
        par_r <= parity_of(hold_r, ODD_L);
      end else begin
        par_r <= par_r;
      end
      txd_r    <= txd_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      done_r   <= done_nxt_s;
    end
  end

  // Holding register: accepts a byte only while empty, flags overrun otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r    <= 8'd0;
      empty_r   <= 1'b1;
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= host.load && !empty_r;
      if (host.load && empty_r) begin
        hold_r  <= host.din;
        empty_r <= 1'b0;
      end else if (load_frame_s) begin
        empty_r <= 1'b1;
      end else begin
        empty_r <= empty_r;
      end
    end
  end

  assign txd          = txd_r;
  assign CS           = state_r;
  assign host.empty   = empty_r;
  assign host.busy    = busy_r;
  assign host.done    = done_r;
  assign host.overrun = overrun_r;

endmodule
